// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared controller state encoding and default frame length
package viterbi_pkg;

    localparam int FRAME_LEN_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ACS,
        TB,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame sequencer driving PMU init, ACS updates, survivor writes and traceback reads
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic                         i_sym_valid,
    output logic                         o_sym_ready,
    output logic                         o_pm_init,
    output logic                         o_acs_en,
    output logic                         o_sm_we,
    output logic [$clog2(FRAME_LEN)-1:0] o_sm_addr,
    output logic                         o_tb_rd,
    output logic [$clog2(FRAME_LEN)-1:0] o_tb_addr,
    output logic                         o_tb_first,
    output logic                         o_dec_valid,
    output logic [$clog2(FRAME_LEN)-1:0] o_dec_idx,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int ADDR_W = $clog2(FRAME_LEN);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [ADDR_W-1:0] tb_q, tb_d;
    logic              dec_valid_q, dec_valid_d;
    logic [ADDR_W-1:0] dec_idx_q, dec_idx_d;
    logic              accept;

    assign accept = i_sym_valid & (state_q == ACS);

    // state, counters and the one-cycle survivor-read-latency pipeline
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            tb_q        <= '0;
            dec_valid_q <= 1'b0;
            dec_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            tb_q        <= tb_d;
            dec_valid_q <= dec_valid_d;
            dec_idx_q   <= dec_idx_d;
        end
    end

    // next state; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = i_start ? INIT : IDLE;
                INIT:    state_d = ACS;
                ACS:     state_d = (accept && step_q == LAST) ? TB : ACS;
                TB:      state_d = (tb_q == '0) ? DONE : TB;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // step counter climbs on accepts, traceback counter sweeps down from the last step
    always_comb begin
        step_d = step_q;
        tb_d   = tb_q;
        if (i_abort) begin
            step_d = '0;
            tb_d   = '0;
        end else if (state_q == INIT) begin
            step_d = '0;
        end else if (accept) begin
            step_d = (step_q == LAST) ? '0 : step_q + 1'b1;
            tb_d   = (step_q == LAST) ? LAST : tb_q;
        end else if (state_q == TB && tb_q != '0) begin
            tb_d = tb_q - 1'b1;
        end
    end

    // decoded strobes and addresses; only acs_en/sm_we look at the input handshake
    always_comb begin
        o_sym_ready = state_q == ACS;
        o_pm_init   = state_q == INIT;
        o_acs_en    = accept;
        o_sm_we     = accept;
        o_sm_addr   = step_q;
        o_tb_rd     = state_q == TB;
        o_tb_addr   = tb_q;
        o_tb_first  = (state_q == TB) && (tb_q == LAST);
        o_busy      = state_q != IDLE;
        o_done      = state_q == DONE;
        o_dec_valid = dec_valid_q;
        o_dec_idx   = dec_idx_q;
        dec_valid_d = !i_abort && (state_q == TB);
        dec_idx_d   = i_abort ? '0 : tb_q;
    end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: directed checks of frame timing, stalls, abort, restart and async reset
module tb_viterbi_frame_ctrl;

    localparam int F = 4;
    localparam int AW = 2;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_sym_valid = 1'b0;
    logic          o_sym_ready, o_pm_init, o_acs_en, o_sm_we;
    logic [AW-1:0] o_sm_addr, o_tb_addr, o_dec_idx;
    logic          o_tb_rd, o_tb_first, o_dec_valid, o_busy, o_done;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    viterbi_frame_ctrl #(.FRAME_LEN(F)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_sym_valid (i_sym_valid),
        .o_sym_ready (o_sym_ready),
        .o_pm_init   (o_pm_init),
        .o_acs_en    (o_acs_en),
        .o_sm_we     (o_sm_we),
        .o_sm_addr   (o_sm_addr),
        .o_tb_rd     (o_tb_rd),
        .o_tb_addr   (o_tb_addr),
        .o_tb_first  (o_tb_first),
        .o_dec_valid (o_dec_valid),
        .o_dec_idx   (o_dec_idx),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int all_outs();
        return int'({o_sym_ready, o_pm_init, o_acs_en, o_sm_we, o_sm_addr, o_tb_rd,
                     o_tb_addr, o_tb_first, o_dec_valid, o_dec_idx, o_busy, o_done});
    endfunction

    // i_start must already be high; the first tick is the sampling edge (edge 0).
    // s = stall cycles after step 1, poke = pulse start in ACS, chain = start in the post-DONE idle cycle
    task automatic run_frame(input int s, input bit poke, input bit chain);
        for (int c = 1; c <= 11 + s; c++) begin
            bit acs, stall, tb, dv;
            tick();
            cyc = c;
            acs   = c >= 2 && c <= 5 + s;
            stall = c >= 4 && c <= 3 + s;
            tb    = c >= 6 + s && c <= 9 + s;
            dv    = c >= 7 + s && c <= 10 + s;
            i_sym_valid = !stall;
            i_start = (poke && c == 3) || (chain && c == 11 + s);
            #1;
            chk("pm_init", o_pm_init, c == 1);
            chk("sym_ready", o_sym_ready, acs);
            chk("acs_en", o_acs_en, acs && !stall);
            chk("sm_we", o_sm_we, acs && !stall);
            chk("sm_addr", o_sm_addr, !acs ? 0 : c < 4 ? c - 2 : stall ? 2 : c - 2 - s);
            chk("tb_rd", o_tb_rd, tb);
            chk("tb_addr", o_tb_addr, tb ? 9 + s - c : 0);
            chk("tb_first", o_tb_first, c == 6 + s);
            chk("dec_valid", o_dec_valid, dv);
            chk("dec_idx", o_dec_idx, dv ? 10 + s - c : 0);
            chk("done", o_done, c == 10 + s);
            chk("busy", o_busy, c <= 10 + s);
        end
    endtask

    initial begin
        #12;
        cyc = 0;
        chk("reset_outs", all_outs(), 0);
        i_rst_n = 1'b1;
        tick();
        chk("idle_busy", o_busy, 0);

        i_sym_valid = 1'b1;
        i_start = 1'b1;
        run_frame(0, 1'b0, 1'b0);

        i_start = 1'b1;
        run_frame(2, 1'b0, 1'b0);

        i_start = 1'b1;
        run_frame(0, 1'b1, 1'b0);

        i_start = 1'b1;
        run_frame(0, 1'b0, 1'b1);
        run_frame(0, 1'b0, 1'b0);

        i_sym_valid = 1'b1;
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        cyc = 100;
        chk("start_abort_busy", o_busy, 0);
        chk("start_abort_init", o_pm_init, 0);
        i_start = 1'b0;
        i_abort = 1'b0;
        tick();
        chk("start_abort_busy2", o_busy, 0);

        i_start = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            tick();
            i_start = 1'b0;
        end
        cyc = 7;
        chk("abort_at_addr", o_tb_addr, 2);
        chk("abort_at_rd", o_tb_rd, 1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        cyc = 8;
        chk("abort_busy", o_busy, 0);
        chk("abort_tb_rd", o_tb_rd, 0);
        chk("abort_dec_valid", o_dec_valid, 0);
        chk("abort_done", o_done, 0);
        for (int c = 9; c <= 11; c++) begin
            tick();
            cyc = c;
            chk("abort_no_done", o_done, 0);
            chk("abort_idle", o_busy, 0);
        end
        i_start = 1'b1;
        run_frame(0, 1'b0, 1'b0);

        i_start = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            tick();
            i_start = 1'b0;
        end
        cyc = 3;
        chk("pre_rst_acs", o_sym_ready, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_outs", all_outs(), 0);
        #3;
        i_rst_n = 1'b1;
        tick();
        cyc = 200;
        chk("post_rst_busy", o_busy, 0);
        chk("post_rst_outs", all_outs(), 0);
        tick();
        chk("post_rst_idle", o_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame-level sequencer for the Viterbi decoder. It accepts a start command and a stream of branch-metric symbols. For each frame it drives the path-metric register initialisation, one add-compare-select update per accepted symbol, survivor-memory writes, and a backward traceback sweep. It sits between the branch-metric front end and the ACS/PMU/survivor-memory/traceback datapath, and it owns every enable and address those blocks consume.

## Interface
- FRAME_LEN, 16: trellis steps per frame; legal values are ≥ 2.
- ADDR_W, $clog2(FRAME_LEN): survivor-memory address width. Derived localparam, not overridable.

Ports (clock and reset first):
- i_clk  in  1  single clock; all state changes on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  begin a frame; sampled only in IDLE.
- i_abort  in  1  synchronous abort to IDLE from any state.
- i_sym_valid  in  1  branch metrics for the current step are present.
- o_sym_ready  out  1  controller accepts a symbol this cycle.
- o_pm_init  out  1  one-cycle pulse; PMU loads its initial metrics.
- o_acs_en  out  1  PMU register load enable; equals accepted handshake.
- o_sm_we  out  1  survivor-memory write strobe.
- o_sm_addr  out  ADDR_W  survivor-memory write address (trellis step).
- o_tb_rd  out  1  traceback read strobe.
- o_tb_addr  out  ADDR_W  traceback read address.
- o_tb_first  out  1  marks the first traceback read; the traceback unit selects the best end state.
- o_dec_valid  out  1  decoded bit from traceback is valid; o_tb_rd delayed by 1 cycle.
- o_dec_idx  out  ADDR_W  trellis index of the decoded bit; o_tb_addr delayed by 1 cycle.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle frame-complete pulse.

## Operation
- States: IDLE, INIT, ACS, TB, DONE. After reset: IDLE, all outputs 0, counters 0.
- IDLE:
  - i_start=1 and i_abort=0 → INIT.
  - i_start is ignored in all other states.
- INIT: lasts 1 cycle. o_pm_init=1 and step_cnt←0, then → ACS.
- ACS:
  - o_sym_ready=1 in this state only.
  - An accept is i_sym_valid & o_sym_ready. On an accept: o_acs_en=1, o_sm_we=1, o_sm_addr=step_cnt, then step_cnt++.
  - When i_sym_valid=0 the state stalls with no strobes.
  - An accept with step_cnt==FRAME_LEN-1 sets tb_cnt←FRAME_LEN-1 and moves to TB.
- TB:
  - o_tb_rd=1 every cycle, o_tb_addr=tb_cnt, o_tb_first=(tb_cnt==FRAME_LEN-1).
  - tb_cnt-- each cycle. A read at tb_cnt==0 moves to DONE.
  - There is no backpressure in TB.
- DONE: lasts 1 cycle. o_done=1 and → IDLE. o_done coincides with the final o_dec_valid (o_dec_idx=0).
- i_abort=1 in any state:
  - Next state is IDLE.
  - All strobes, including the o_dec_valid pipeline register, are 0 from the next cycle.
  - Counters clear.
  - o_done is not asserted.
  - Abort has priority over start, accept and all transitions.
- Asynchronous reset mid-frame: immediate return to the reset values above. No partial-frame recovery.
- Counter arithmetic: step_cnt counts up and never exceeds FRAME_LEN-1. tb_cnt counts down and never wraps below 0. Both are ADDR_W bits; for non-power-of-2 FRAME_LEN, the values from FRAME_LEN to 2^ADDR_W-1 are never reached.
- o_sym_ready, o_acs_en, o_sm_we, o_tb_rd, o_tb_first and o_pm_init are decoded from state and counters (Moore). The exceptions are o_acs_en and o_sm_we, which also gate on i_sym_valid.

## Timing
- i_start sampled at edge 0 → INIT during cycle 1 → ACS from cycle 2.
- With i_sym_valid held high:
  - ACS occupies cycles 2 to FRAME_LEN+1.
  - TB occupies FRAME_LEN+2 to 2·FRAME_LEN+1.
  - DONE is cycle 2·FRAME_LEN+2, and IDLE follows in the next cycle.
- Start-to-done is 2·FRAME_LEN+2 cycles plus one cycle per ACS stall.
- Back-to-back frames: i_start may be high in the first IDLE cycle after DONE. There is a minimum 1-cycle IDLE gap between frames.
- o_dec_valid/o_dec_idx lag o_tb_rd/o_tb_addr by exactly 1 cycle, matching the survivor-memory read latency.

## Structure
- Shared package viterbi_pkg holds:
  - the state enum typedef (ctrl_state_t: IDLE, INIT, ACS, TB, DONE);
  - the default FRAME_LEN constant, shared with the survivor-memory depth.
- The block is a single module: one FSM, two counters and a 1-stage output register. No sub-module is warranted.

## Test plan (FRAME_LEN=4)
- Reset then start, i_sym_valid held 1:
  - o_pm_init at cycle 1.
  - o_sm_addr 0,1,2,3 with o_sm_we in cycles 2–5.
  - o_tb_addr 3,2,1,0 in cycles 6–9; o_tb_first only in cycle 6.
  - o_dec_idx 3,2,1,0 in cycles 7–10.
  - o_done in cycle 10, o_busy low in cycle 11.
- i_sym_valid low for 2 cycles after step 1 is accepted: no o_acs_en/o_sm_we during the stall; step 2 is written at address 2; o_done is 2 cycles later than in scenario 1.
- i_abort during TB at o_tb_addr=2: next cycle is IDLE with o_tb_rd=0 and o_dec_valid=0; o_done never pulses; a new i_start restarts at o_sm_addr=0.
- i_start pulsed during ACS: ignored, with no extra o_pm_init. i_start and i_abort both high in IDLE: remains IDLE with o_busy=0.
- i_start high in the IDLE cycle right after DONE: a second frame runs with identical timing; o_pm_init fires once per frame.
- Asynchronous reset asserted mid-ACS (not on a clock edge): all outputs 0 immediately; after release the FSM is in IDLE.
